alu_rr_scheduler: RTL and testbench
===================================

ALU_RR_SCHEDULER -- requirements
Module: alu_rr_scheduler

Interface
REQ-001 SHALL have no parameters: width fixed at 4 bits and two requesters, matching the shared ALU.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port req_valid, input, 2: bit i high means requester i presents an operation.
REQ-005 SHALL have port req_ready, output, 2: bit i high means the scheduler accepts requester i this cycle.
REQ-006 SHALL have port req_a, input, 8: operand A; requester i uses bits [4i+3:4i].
REQ-007 SHALL have port req_b, input, 8: operand B; same packing as req_a.
REQ-008 SHALL have port req_sel, input, 6: opcode; requester i uses bits [3i+2:3i].
REQ-009 SHALL have port rsp_valid, output, 2: one-hot; bit i high means the response for requester i is valid.
REQ-010 SHALL have port rsp_ready, input, 2: bit i high means requester i consumes its response.
REQ-011 SHALL have port rsp_result, output, 4: registered ALU result, meaningful only while any rsp_valid bit is high.
REQ-012 SHALL have port rsp_cout, output, 1: registered ALU carry-out.
REQ-013 SHALL have port rsp_illegal, output, 1: high with the response when the captured opcode was greater than 3'b100.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port op_count, output, 8: count of completed response handshakes.

Function
REQ-016 SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-017 In IDLE, when any req_valid bit is high, the scheduler SHALL:
- pick grant g by round-robin;
- drive req_ready[g]=1 for that cycle only, combinationally from req_valid and the priority pointer;
- capture a, b and sel of requester g plus g itself;
- go to EXEC.
REQ-018 Round-robin rule SHALL be:
- if both requesters are valid, grant the requester other than last_grant;
- if only one is valid, grant it regardless of last_grant.
REQ-019 req_ready SHALL be 2'b00 in EXEC and RESP, and never have more than one bit set.
REQ-020 In EXEC, the scheduler SHALL drive the shared ALU from the captured registers, register result and cout into the rsp_* outputs, and go to RESP.
REQ-021 In RESP, the scheduler SHALL:
- hold rsp_valid[g]=1 and keep rsp_result, rsp_cout and rsp_illegal stable until rsp_ready[g]=1;
- on that handshake, set last_grant=g, increment op_count, and go to IDLE.
REQ-022 rsp_ready on the non-granted bit SHALL be ignored.
REQ-023 Latency SHALL be: request accepted in cycle N, rsp_valid asserted in cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-024 Opcodes SHALL be 000 ADD, 001 SUB (a+~b+1, cout=no-borrow), 010 AND, 011 OR, 100 XOR; logical ops give cout=0.
REQ-025 Opcodes 101 to 111 SHALL give result 4'b0000, cout 0 and rsp_illegal 1, and still complete normally.
REQ-026 op_count SHALL wrap from 255 to 0 without affecting any other behaviour.
REQ-027 A requester that drops req_valid while not granted SHALL simply not be served; no state is kept for it.
REQ-028 Requests arriving in EXEC or RESP SHALL wait; the scheduler holds no queue.

Reset
REQ-029 When rst=1 at a clock edge, outputs and state SHALL go to:
- state=IDLE, last_grant=1 (so requester 0 wins the first tie);
- rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_illegal=0;
- op_count=0, busy=0.
REQ-030 Reset asserted in EXEC or RESP SHALL abandon the in-flight operation with no response and no op_count increment.
REQ-031 req_ready SHALL be 2'b00 during any cycle in which rst=1.

Structure
REQ-032 Shared package alu_pkg SHALL hold the opcode constants (ALU_ADD to ALU_XOR), the FSM state encoding and the width constant 4.
REQ-033 The block SHALL instantiate exactly one existing simple_alu as the sub-module (ports a, b, sel, result, cout) and SHALL NOT duplicate its arithmetic.

Verification
REQ-034 Single requester, requester 0, a=1010, b=0101, sel=000: rsp_valid=01 two cycles after accept, result=1111, cout=0.
REQ-035 Single requester, same operands, sel=001: result=0101, cout=1; sel=100: result=1111, cout=0.
REQ-036 Both requesters valid continuously from reset: grants alternate 0,1,0,1 and op_count=4 after four handshakes.
REQ-037 rsp_ready held at 0 for 5 cycles in RESP: outputs stay stable and req_ready stays 00; the response completes once rsp_ready=1.
REQ-038 sel=111 gives result=0000, cout=0, rsp_illegal=1; reset pulsed in EXEC gives no rsp_valid and op_count unchanged.
REQ-039 256 back-to-back operations make op_count wrap to 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the 4-bit ALU and its round-robin
//               scheduler: operand width, opcodes, FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    // Opcodes above XOR are unassigned and reported as illegal.
    function automatic logic is_illegal(input logic [2:0] sel);
        return (sel > ALU_XOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/simple_alu.sv
`default_nettype none
// ============================================================================
// Module      : simple_alu
// Description : Combinational 4-bit ALU (ADD, SUB, AND, OR, XOR). Unassigned
//               opcodes yield zero result and zero carry.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       sel,
    output logic [ALU_W-1:0] result,
    output logic             cout
);

    logic [ALU_W:0] sum;

    // Opcode decode; subtraction is a + ~b + 1 so cout means "no borrow".
    always_comb begin
        sum    = '0;
        result = '0;
        cout   = 1'b0;
        case (sel)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[ALU_W-1:0];
                cout   = sum[ALU_W];
            end
            ALU_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
                result = sum[ALU_W-1:0];
                cout   = sum[ALU_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: begin
                result = '0;
                cout   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_scheduler
// Description : Shares one 4-bit ALU between two requesters. Round-robin
//               grant in IDLE, one execute cycle, then a held response until
//               the granted requester consumes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [7:0]   req_a,
    input  logic [7:0]   req_b,
    input  logic [5:0]   req_sel,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [3:0]   rsp_result,
    output logic         rsp_cout,
    output logic         rsp_illegal,
    output logic         busy,
    output logic [7:0]   op_count
);

    sched_state_e     state_q, state_d;
    logic             grant_q;
    logic             last_grant_q;
    logic [ALU_W-1:0] a_q, b_q;
    logic [2:0]       sel_q;
    logic [ALU_W-1:0] result_q;
    logic             cout_q;
    logic             illegal_q;
    logic [7:0]       op_count_q;

    logic             grant_d;
    logic             accept;
    logic             handshake;
    logic [ALU_W-1:0] alu_result;
    logic             alu_cout;

    // Round-robin pick: on a tie the requester that did not go last wins,
    // otherwise whichever single requester is valid.
    always_comb begin
        grant_d   = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        accept    = (state_q == ST_IDLE) && (|req_valid) && !rst;
        req_ready = accept ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
        handshake = (state_q == ST_RESP) && rsp_ready[grant_q];
    end

    // Next-state logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_RESP;
            ST_RESP: if (handshake) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    simple_alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .sel    (sel_q),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // State, request capture, response registers and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            result_q     <= '0;
            cout_q       <= 1'b0;
            illegal_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= grant_d;
                a_q     <= grant_d ? req_a[7:4]   : req_a[3:0];
                b_q     <= grant_d ? req_b[7:4]   : req_b[3:0];
                sel_q   <= grant_d ? req_sel[5:3] : req_sel[2:0];
            end
            if (state_q == ST_EXEC) begin
                result_q  <= alu_result;
                cout_q    <= alu_cout;
                illegal_q <= is_illegal(sel_q);
            end
            if (handshake) begin
                last_grant_q <= grant_q;
                op_count_q   <= op_count_q + 8'd1;
            end
        end
    end

    assign rsp_valid   = (state_q == ST_RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result  = result_q;
    assign rsp_cout    = cout_q;
    assign rsp_illegal = illegal_q;
    assign busy        = (state_q != ST_IDLE);
    assign op_count    = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_scheduler
// Description : Directed, table-driven self-checking bench for
//               alu_rr_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0] req_a, req_b;
    logic [5:0] req_sel;
    logic [3:0] rsp_result;
    logic       rsp_cout, rsp_illegal, busy;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;
    int exp_count;

    typedef struct {
        int unsigned r;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [2:0]  sel;
        logic [3:0]  res;
        logic        cout;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    alu_rr_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sel     (req_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_cout    (rsp_cout),
        .rsp_illegal (rsp_illegal),
        .busy        (busy),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int unsigned r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        exp_count = 0;
    endtask

    // One full operation from accept to handshake; optional stall in RESP.
    task automatic run_vec(input vec_t v, input int stall);
        logic [1:0] oh;
        oh = onehot(v.r);
        req_a = 8'h00; req_b = 8'h00; req_sel = 6'h00;
        if (v.r == 1) begin
            req_a[7:4] = v.a; req_b[7:4] = v.b; req_sel[5:3] = v.sel;
        end else begin
            req_a[3:0] = v.a; req_b[3:0] = v.b; req_sel[2:0] = v.sel;
        end
        req_valid = oh;
        rsp_ready = 2'b00;
        #1;
        check("accept_ready", {30'd0, req_ready}, {30'd0, oh});
        check("idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        check("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("exec_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("resp_valid", {30'd0, rsp_valid}, {30'd0, oh});
        check("resp_result", {28'd0, rsp_result}, {28'd0, v.res});
        check("resp_cout", {31'd0, rsp_cout}, {31'd0, v.cout});
        check("resp_illegal", {31'd0, rsp_illegal}, {31'd0, v.ill});
        for (int s = 0; s < stall; s++) begin
            req_valid = 2'b11;
            rsp_ready = ~oh;
            @(negedge clk);
            check("stall_valid", {30'd0, rsp_valid}, {30'd0, oh});
            check("stall_result", {28'd0, rsp_result}, {28'd0, v.res});
            check("stall_cout", {31'd0, rsp_cout}, {31'd0, v.cout});
            check("stall_req_ready", {30'd0, req_ready}, 32'd0);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        exp_count = (exp_count + 1) % 256;
        check("done_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("done_op_count", {24'd0, op_count}, exp_count);
        rsp_ready = 2'b00;
    endtask

    initial begin
        vecs[0]  = '{0, 4'b1010, 4'b0101, 3'b000, 4'b1111, 1'b0, 1'b0};
        vecs[1]  = '{0, 4'b1010, 4'b0101, 3'b001, 4'b0101, 1'b1, 1'b0};
        vecs[2]  = '{0, 4'b1010, 4'b0101, 3'b100, 4'b1111, 1'b0, 1'b0};
        vecs[3]  = '{1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b0};
        vecs[4]  = '{1, 4'b0011, 4'b0101, 3'b001, 4'b1110, 1'b0, 1'b0};
        vecs[5]  = '{0, 4'b1100, 4'b1010, 3'b010, 4'b1000, 1'b0, 1'b0};
        vecs[6]  = '{1, 4'b1100, 4'b1010, 3'b011, 4'b1110, 1'b0, 1'b0};
        vecs[7]  = '{0, 4'b1010, 4'b0101, 3'b111, 4'b0000, 1'b0, 1'b1};
        vecs[8]  = '{1, 4'b1111, 4'b1111, 3'b101, 4'b0000, 1'b0, 1'b1};
        vecs[9]  = '{0, 4'b0101, 4'b0101, 3'b001, 4'b0000, 1'b1, 1'b0};
        vecs[10] = '{0, 4'b1010, 4'b0101, 3'b010, 4'b0000, 1'b0, 1'b0};

        req_a = 8'h00; req_b = 8'h00; req_sel = 6'h00;

        // Reset with a request pending: no grant while rst is high.
        rst       = 1'b1;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        @(negedge clk);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rst_req_ready2", {30'd0, req_ready}, 32'd0);
        rst       = 1'b0;
        req_valid = 2'b00;
        exp_count = 0;
        #1;
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_result", {28'd0, rsp_result}, 32'd0);
        check("reset_cout", {31'd0, rsp_cout}, 32'd0);
        check("reset_illegal", {31'd0, rsp_illegal}, 32'd0);
        check("reset_op_count", {24'd0, op_count}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Table of single-requester operations; vector 3 also stalls in RESP.
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], (i == 3) ? 5 : 0);
        end

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        do_reset();
        req_a = 8'h21; req_b = 8'h13; req_sel = 6'b000_000;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            check("rr_req_ready", {30'd0, req_ready}, {30'd0, exp_g});
            @(negedge clk);
            @(negedge clk);
            check("rr_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_g});
            check("rr_result", {28'd0, rsp_result}, (k % 2 == 1) ? 32'h3 : 32'h4);
            @(negedge clk);
        end
        check("rr_op_count", {24'd0, op_count}, 32'd4);
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        // Reset pulsed during EXEC abandons the operation.
        do_reset();
        req_a = 8'h05; req_b = 8'h03; req_sel = 6'b000_000;
        req_valid = 2'b01;
        @(negedge clk);
        check("rexec_busy_before", {31'd0, busy}, 32'd1);
        req_valid = 2'b00;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rexec_busy", {31'd0, busy}, 32'd0);
        check("rexec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rexec_rsp_valid_late", {30'd0, rsp_valid}, 32'd0);
        check("rexec_op_count", {24'd0, op_count}, 32'd0);

        // 256 back-to-back operations wrap op_count to zero.
        do_reset();
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        repeat (765) @(negedge clk);
        check("wrap_255", {24'd0, op_count}, 32'd255);
        repeat (3) @(negedge clk);
        check("wrap_0", {24'd0, op_count}, 32'd0);
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
